// File: rtl/control_unit_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg: shared types and constants for the control_unit slice.
//   state_t   - FSM state encoding
//   iclass_t  - instruction class produced by cu_decode
//   OP_*      - opcode field (ir_1) values
//   FN_*      - ALU function select codes (fnSelect)
//   helpers   - small predicates on instruction class
// -----------------------------------------------------------------------------
package cu_pkg;

    typedef enum logic [3:0] {
        FETCH_ADDR,
        FETCH_MEM,
        FETCH_IR,
        DECODE,
        EXEC,
        MEM_ADDR,
        MEM_ACC,
        WB,
        HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP,
        CL_PUSH,
        CL_POP,
        CL_HALT,
        CL_ILLEGAL
    } iclass_t;

    localparam logic [3:0] OP_ALU    = 4'b0000;
    localparam logic [3:0] OP_LOAD   = 4'b0001;
    localparam logic [3:0] OP_STORE  = 4'b0010;
    localparam logic [3:0] OP_BRANCH = 4'b0011;
    localparam logic [3:0] OP_JUMP   = 4'b0100;
    localparam logic [3:0] OP_PUSH   = 4'b0101;
    localparam logic [3:0] OP_POP    = 4'b0110;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    localparam logic [2:0] FN_ADD = 3'b000;
    localparam logic [2:0] FN_SUB = 3'b001;
    localparam logic [2:0] FN_AND = 3'b010;
    localparam logic [2:0] FN_OR  = 3'b011;
    localparam logic [2:0] FN_XOR = 3'b100;
    localparam logic [2:0] FN_NOT = 3'b101;
    localparam logic [2:0] FN_SHL = 3'b110;
    localparam logic [2:0] FN_SHR = 3'b111;
    // Value driven on fnSelect whenever the ALU is not in use.
    localparam logic [2:0] FN_IDLE = FN_ADD;

    // Classes whose memory access is a read (result lands in MDR, then WB).
    function automatic logic cls_is_read(iclass_t c);
        return (c == CL_LOAD) || (c == CL_POP);
    endfunction

    // Classes whose address comes from the stack pointer rather than the label.
    function automatic logic cls_uses_sp(iclass_t c);
        return (c == CL_PUSH) || (c == CL_POP);
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// -----------------------------------------------------------------------------
// control_unit_if: bundle between the control unit and the datapath/memory.
//   IR fields : ir_1 (opcode), ir_2 (mode, bit0 = immediate), funct, cc
//   memory    : mem_rd, mem_wr (requests), mem_ready (completion strobe)
//   loads     : ldMAR ldMDR ldIR ldPC ldSP ldReg ldALUreg ldFlag
//   bus drive : Tpc Tsp Tmdr Treg Tlabel
//   ALU       : ALUon, fnSelect, mm
//   status    : halted, illegal, bus_err (sticky)
// modport master = control unit side, slave = datapath/memory side.
// -----------------------------------------------------------------------------
interface control_unit_if;
    logic [3:0] ir_1;
    logic [1:0] ir_2;
    logic [2:0] funct;
    logic       cc;
    logic       mem_ready;

    logic       ldMAR, ldMDR, ldIR, ldPC, ldSP, ldReg, ldALUreg, ldFlag;
    logic       Tpc, Tsp, Tmdr, Treg, Tlabel;
    logic       ALUon;
    logic [2:0] fnSelect;
    logic       mm;
    logic       mem_rd, mem_wr;
    logic       halted, illegal, bus_err;

    modport master (
        input  ir_1, ir_2, funct, cc, mem_ready,
        output ldMAR, ldMDR, ldIR, ldPC, ldSP, ldReg, ldALUreg, ldFlag,
        output Tpc, Tsp, Tmdr, Treg, Tlabel,
        output ALUon, fnSelect, mm, mem_rd, mem_wr,
        output halted, illegal, bus_err
    );

    modport slave (
        output ir_1, ir_2, funct, cc, mem_ready,
        input  ldMAR, ldMDR, ldIR, ldPC, ldSP, ldReg, ldALUreg, ldFlag,
        input  Tpc, Tsp, Tmdr, Treg, Tlabel,
        input  ALUon, fnSelect, mm, mem_rd, mem_wr,
        input  halted, illegal, bus_err
    );
endinterface

// File: rtl/control_unit_decode.sv
// -----------------------------------------------------------------------------
// cu_decode: combinational opcode -> instruction class.
//   opcode : in  [3:0] ir_1 field
//   iclass : out       instruction class (CL_ILLEGAL for unknown opcodes)
// Config macro CU_STACK_EN: when defined PUSH/POP decode to their classes,
// otherwise those opcodes fall through to CL_ILLEGAL.
// -----------------------------------------------------------------------------
module cu_decode
    import cu_pkg::*;
(
    input  logic [3:0] opcode,
    output iclass_t    iclass
);

    always_comb begin
        iclass = CL_ILLEGAL;
        case (opcode)
            OP_ALU:    iclass = CL_ALU;
            OP_LOAD:   iclass = CL_LOAD;
            OP_STORE:  iclass = CL_STORE;
            OP_BRANCH: iclass = CL_BRANCH;
            OP_JUMP:   iclass = CL_JUMP;
`ifdef CU_STACK_EN
            OP_PUSH:   iclass = CL_PUSH;
            OP_POP:    iclass = CL_POP;
`else
            // Stack ops are not built in: treat them like any unknown opcode.
            OP_PUSH,
            OP_POP:    iclass = CL_ILLEGAL;
`endif
            OP_HALT:   iclass = CL_HALT;
            default:   iclass = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit: multi-cycle microsequencer for a simple accumulator/stack CPU.
//   clk   : in  rising-edge clock
//   reset : in  asynchronous active-low reset
//   bus   : control_unit_if.master (IR fields, memory handshake, datapath
//           load/tristate enables, ALU controls, sticky status flags)
// Parameter TIMEOUT_CYCLES: wait-counter value at which an unanswered memory
// request is abandoned, bus_err is raised and the FSM halts.
// Config macro CU_STACK_EN (in cu_decode) enables PUSH/POP.
//
// Outputs are decoded from the current state; a few strobes are qualified by
// live inputs (ldMDR by mem_ready on reads, ldPC by cc on branches).
// -----------------------------------------------------------------------------
module control_unit
    import cu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic           clk,
    input  logic           reset,
    control_unit_if.master bus
);

    localparam int CNT_REQ = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_REQ > 4) ? CNT_REQ : 4;

    state_t           state, next;
    iclass_t          dec_cls, cls_q;
    logic             run;        // low until the first edge after reset
    logic [CNT_W-1:0] wait_cnt;
    logic             in_wait;
    logic             timeout;
    logic             halted_q, illegal_q, bus_err_q;

    cu_decode u_decode (
        .opcode (bus.ir_1),
        .iclass (dec_cls)
    );

    assign in_wait = (state == FETCH_MEM) || (state == MEM_ACC);
    // mem_ready in the expiry cycle still completes the access.
    assign timeout = in_wait && !bus.mem_ready &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

    // State register. The first edge after reset only arms 'run', so that
    // edge is the one that exposes the FETCH_ADDR outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH_ADDR;
            run   <= 1'b0;
        end else begin
            state <= next;
            run   <= 1'b1;
        end
    end

    // Latched class, wait counter and sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cls_q     <= CL_ILLEGAL;
            wait_cnt  <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            if (state == DECODE)
                cls_q <= dec_cls;
            // Zero on every entry into a wait state; count while stalled.
            if (in_wait && (next == state))
                wait_cnt <= wait_cnt + CNT_W'(1);
            else
                wait_cnt <= '0;
            if (next == HALT)
                halted_q <= 1'b1;
            if (timeout)
                bus_err_q <= 1'b1;
            if ((state == DECODE) && (dec_cls == CL_ILLEGAL))
                illegal_q <= 1'b1;
        end
    end

    // Next state and outputs.
    always_comb begin
        next         = state;
        bus.ldMAR    = 1'b0;
        bus.ldMDR    = 1'b0;
        bus.ldIR     = 1'b0;
        bus.ldPC     = 1'b0;
        bus.ldSP     = 1'b0;
        bus.ldReg    = 1'b0;
        bus.ldALUreg = 1'b0;
        bus.ldFlag   = 1'b0;
        bus.Tpc      = 1'b0;
        bus.Tsp      = 1'b0;
        bus.Tmdr     = 1'b0;
        bus.Treg     = 1'b0;
        bus.Tlabel   = 1'b0;
        bus.ALUon    = 1'b0;
        bus.fnSelect = FN_IDLE;
        bus.mm       = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.mem_wr   = 1'b0;

        case (state)
            FETCH_ADDR: begin
                if (run) begin
                    bus.Tpc   = 1'b1;
                    bus.ldMAR = 1'b1;
                    next      = FETCH_MEM;
                end
            end

            FETCH_MEM: begin
                bus.mem_rd = 1'b1;
                bus.ldMDR  = bus.mem_ready;
                if (bus.mem_ready)
                    next = FETCH_IR;
                else if (timeout)
                    next = HALT;
            end

            FETCH_IR: begin
                bus.Tmdr = 1'b1;
                bus.ldIR = 1'b1;
                bus.ldPC = 1'b1;
                next     = DECODE;
            end

            DECODE: begin
                case (dec_cls)
                    CL_ALU, CL_BRANCH, CL_JUMP:        next = EXEC;
                    CL_LOAD, CL_STORE, CL_PUSH, CL_POP: next = MEM_ADDR;
                    CL_HALT:                            next = HALT;
                    default:                            next = FETCH_ADDR;
                endcase
            end

            EXEC: begin
                if (cls_q == CL_ALU) begin
                    bus.ALUon    = 1'b1;
                    bus.fnSelect = bus.funct;
                    bus.mm       = bus.ir_2[0];
                    bus.ldALUreg = 1'b1;
                    bus.ldFlag   = 1'b1;
                    next         = WB;
                end else begin
                    bus.Tlabel = 1'b1;
                    bus.ldPC   = (cls_q == CL_JUMP) ? 1'b1 : bus.cc;
                    next       = FETCH_ADDR;
                end
            end

            MEM_ADDR: begin
                bus.ldMAR = 1'b1;
                if (cls_uses_sp(cls_q))
                    bus.Tsp = 1'b1;
                else
                    bus.Tlabel = 1'b1;
                // PUSH pre-decrements SP alongside the address load.
                bus.ldSP = (cls_q == CL_PUSH);
                next     = MEM_ACC;
            end

            MEM_ACC: begin
                if (cls_is_read(cls_q)) begin
                    bus.mem_rd = 1'b1;
                    bus.ldMDR  = bus.mem_ready;
                end else begin
                    bus.Treg   = 1'b1;
                    bus.ldMDR  = 1'b1;
                    bus.mem_wr = 1'b1;
                end
                if (bus.mem_ready)
                    next = cls_is_read(cls_q) ? WB : FETCH_ADDR;
                else if (timeout)
                    next = HALT;
            end

            WB: begin
                bus.ldReg = 1'b1;
                bus.Tmdr  = cls_is_read(cls_q);
                // POP post-increments SP once the data is written back.
                bus.ldSP  = (cls_q == CL_POP);
                next      = FETCH_ADDR;
            end

            HALT: next = HALT;

            default: next = FETCH_ADDR;
        endcase
    end

    assign bus.halted  = halted_q;
    assign bus.illegal = illegal_q;
    assign bus.bus_err = bus_err_q;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit: directed self-checking bench for control_unit (default
// build, CU_STACK_EN undefined). Inputs change 1 ns after the rising edge and
// outputs are compared a further ns later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_control_unit;

    localparam logic [16:0] B_LDMAR  = 17'h10000;
    localparam logic [16:0] B_LDMDR  = 17'h08000;
    localparam logic [16:0] B_LDIR   = 17'h04000;
    localparam logic [16:0] B_LDPC   = 17'h02000;
    localparam logic [16:0] B_LDSP   = 17'h01000;
    localparam logic [16:0] B_LDREG  = 17'h00800;
    localparam logic [16:0] B_LDALU  = 17'h00400;
    localparam logic [16:0] B_LDFLAG = 17'h00200;
    localparam logic [16:0] B_TPC    = 17'h00100;
    localparam logic [16:0] B_TSP    = 17'h00080;
    localparam logic [16:0] B_TMDR   = 17'h00040;
    localparam logic [16:0] B_TREG   = 17'h00020;
    localparam logic [16:0] B_TLABEL = 17'h00010;
    localparam logic [16:0] B_ALUON  = 17'h00008;
    localparam logic [16:0] B_MM     = 17'h00004;
    localparam logic [16:0] B_MEMRD  = 17'h00002;
    localparam logic [16:0] B_MEMWR  = 17'h00001;

    localparam logic [16:0] C_FA = B_TPC | B_LDMAR;
    localparam logic [16:0] C_FI = B_TMDR | B_LDIR | B_LDPC;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    control_unit_if cu_bus ();

    control_unit #(.TIMEOUT_CYCLES(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (cu_bus)
    );

    always #5 clk = ~clk;

    logic [16:0] ctl;
    assign ctl = {cu_bus.ldMAR, cu_bus.ldMDR, cu_bus.ldIR, cu_bus.ldPC,
                  cu_bus.ldSP, cu_bus.ldReg, cu_bus.ldALUreg, cu_bus.ldFlag,
                  cu_bus.Tpc, cu_bus.Tsp, cu_bus.Tmdr, cu_bus.Treg,
                  cu_bus.Tlabel, cu_bus.ALUon, cu_bus.mm,
                  cu_bus.mem_rd, cu_bus.mem_wr};

    logic [2:0] flags;  // {halted, illegal, bus_err}
    assign flags = {cu_bus.halted, cu_bus.illegal, cu_bus.bus_err};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses reset between edges and leaves the DUT showing FETCH_ADDR.
    task automatic do_reset();
        cu_bus.mem_ready = 1'b0;
        reset = 1'b0;
        #3;
        reset = 1'b1;
        step();
    endtask

    // From FETCH_ADDR: fetch with wait_n stall cycles, end in DECODE.
    task automatic fetch(input int wait_n);
        cu_bus.mem_ready = 1'b0;
        step();
        repeat (wait_n) step();
        cu_bus.mem_ready = 1'b1;
        step();
        cu_bus.mem_ready = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cu_bus.ir_1 = 4'b0000; cu_bus.ir_2 = 2'b00; cu_bus.funct = 3'b000;
        cu_bus.cc = 1'b0; cu_bus.mem_ready = 1'b1;
        repeat (3) step();
        checks++; if (ctl !== 17'h0) begin errors++; $display("FAIL reset_ctl: got %h want %h", ctl, 17'h0); end
        checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want %b", flags, 3'b000); end
        checks++; if (cu_bus.fnSelect !== 3'b000) begin errors++; $display("FAIL reset_fn: got %b want %b", cu_bus.fnSelect, 3'b000); end
        cu_bus.mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (ctl !== 17'h0) begin errors++; $display("FAIL release_pre_edge: got %h want %h", ctl, 17'h0); end
        step();
        checks++; if (ctl !== C_FA) begin errors++; $display("FAIL first_edge_fa: got %h want %h", ctl, C_FA); end
    endtask

    // Fetch with mem_ready two cycles after mem_rd, then a JUMP.
    task automatic test_fetch();
        cu_bus.ir_1 = 4'b0100; cu_bus.cc = 1'b0;
        step();
        checks++; if (ctl !== B_MEMRD) begin errors++; $display("FAIL fetch_mem0: got %h want %h", ctl, B_MEMRD); end
        step();
        checks++; if (ctl !== B_MEMRD) begin errors++; $display("FAIL fetch_mem1: got %h want %h", ctl, B_MEMRD); end
        step();
        cu_bus.mem_ready = 1'b1;
        #1;
        checks++; if (ctl !== (B_MEMRD | B_LDMDR)) begin errors++; $display("FAIL fetch_ready: got %h want %h", ctl, B_MEMRD | B_LDMDR); end
        step();
        cu_bus.mem_ready = 1'b0;
        #1;
        checks++; if (ctl !== C_FI) begin errors++; $display("FAIL fetch_ir: got %h want %h", ctl, C_FI); end
        step();
        checks++; if (ctl !== 17'h0) begin errors++; $display("FAIL decode_idle: got %h want %h", ctl, 17'h0); end
        step();
        checks++; if (ctl !== (B_TLABEL | B_LDPC)) begin errors++; $display("FAIL jump_exec: got %h want %h", ctl, B_TLABEL | B_LDPC); end
        step();
        checks++; if (ctl !== C_FA) begin errors++; $display("FAIL jump_back_fa: got %h want %h", ctl, C_FA); end
    endtask

    task automatic test_alu();
        logic [2:0]  fn_v [2] = '{3'b100, 3'b011};
        logic [1:0]  md_v [2] = '{2'b01, 2'b10};
        logic [16:0] ex_v [2] = '{B_ALUON | B_MM | B_LDALU | B_LDFLAG,
                                  B_ALUON | B_LDALU | B_LDFLAG};
        for (int i = 0; i < 2; i++) begin
            cu_bus.ir_1 = 4'b0000; cu_bus.funct = fn_v[i]; cu_bus.ir_2 = md_v[i];
            fetch(1);
            step();
            cu_bus.mem_ready = 1'b1;  // stray strobe outside a wait state
            #1;
            checks++; if (ctl !== ex_v[i]) begin errors++; $display("FAIL alu_exec[%0d]: got %h want %h", i, ctl, ex_v[i]); end
            checks++; if (cu_bus.fnSelect !== fn_v[i]) begin errors++; $display("FAIL alu_fn[%0d]: got %b want %b", i, cu_bus.fnSelect, fn_v[i]); end
            cu_bus.mem_ready = 1'b0;
            step();
            checks++; if (ctl !== B_LDREG) begin errors++; $display("FAIL alu_wb[%0d]: got %h want %h", i, ctl, B_LDREG); end
            checks++; if (cu_bus.fnSelect !== 3'b000) begin errors++; $display("FAIL alu_wb_fn[%0d]: got %b want %b", i, cu_bus.fnSelect, 3'b000); end
            step();
            checks++; if (ctl !== C_FA) begin errors++; $display("FAIL alu_back_fa[%0d]: got %h want %h", i, ctl, C_FA); end
        end
    endtask

    task automatic test_branch();
        logic [16:0] exp;
        for (int c = 0; c < 2; c++) begin
            cu_bus.ir_1 = 4'b0011; cu_bus.cc = c[0];
            fetch(0);
            step();
            exp = (c == 1) ? (B_TLABEL | B_LDPC) : B_TLABEL;
            checks++; if (ctl !== exp) begin errors++; $display("FAIL branch_cc%0d: got %h want %h", c, ctl, exp); end
            step();
            checks++; if (ctl !== C_FA) begin errors++; $display("FAIL branch_fa_cc%0d: got %h want %h", c, ctl, C_FA); end
        end
        cu_bus.cc = 1'b0;
    endtask

    task automatic test_load();
        cu_bus.ir_1 = 4'b0001;
        fetch(0);
        step();
        checks++; if (ctl !== (B_TLABEL | B_LDMAR)) begin errors++; $display("FAIL load_addr: got %h want %h", ctl, B_TLABEL | B_LDMAR); end
        step();
        checks++; if (ctl !== B_MEMRD) begin errors++; $display("FAIL load_wait: got %h want %h", ctl, B_MEMRD); end
        cu_bus.mem_ready = 1'b1;
        #1;
        checks++; if (ctl !== (B_MEMRD | B_LDMDR)) begin errors++; $display("FAIL load_ready: got %h want %h", ctl, B_MEMRD | B_LDMDR); end
        step();
        cu_bus.mem_ready = 1'b0;
        #1;
        checks++; if (ctl !== (B_TMDR | B_LDREG)) begin errors++; $display("FAIL load_wb: got %h want %h", ctl, B_TMDR | B_LDREG); end
        step();
        checks++; if (ctl !== C_FA) begin errors++; $display("FAIL load_fa: got %h want %h", ctl, C_FA); end
    endtask

    task automatic test_store();
        cu_bus.ir_1 = 4'b0010;
        fetch(0);
        step();
        checks++; if (ctl !== (B_TLABEL | B_LDMAR)) begin errors++; $display("FAIL store_addr: got %h want %h", ctl, B_TLABEL | B_LDMAR); end
        step();
        step();
        checks++; if (ctl !== (B_TREG | B_LDMDR | B_MEMWR)) begin errors++; $display("FAIL store_hold: got %h want %h", ctl, B_TREG | B_LDMDR | B_MEMWR); end
        cu_bus.mem_ready = 1'b1;
        step();
        cu_bus.mem_ready = 1'b0;
        #1;
        checks++; if (ctl !== C_FA) begin errors++; $display("FAIL store_fa: got %h want %h", ctl, C_FA); end
    endtask

    // mem_ready arriving in the very cycle the counter reaches 15 wins.
    task automatic test_timeout_race();
        cu_bus.ir_1 = 4'b0000;
        cu_bus.mem_ready = 1'b0;
        step();
        repeat (15) step();
        checks++; if (ctl !== B_MEMRD) begin errors++; $display("FAIL race_last_wait: got %h want %h", ctl, B_MEMRD); end
        cu_bus.mem_ready = 1'b1;
        step();
        cu_bus.mem_ready = 1'b0;
        #1;
        checks++; if (ctl !== C_FI) begin errors++; $display("FAIL race_fetch_ir: got %h want %h", ctl, C_FI); end
        checks++; if (flags !== 3'b000) begin errors++; $display("FAIL race_flags: got %b want %b", flags, 3'b000); end
        repeat (4) step();
        checks++; if (ctl !== C_FA) begin errors++; $display("FAIL race_fa: got %h want %h", ctl, C_FA); end
    endtask

    task automatic test_illegal();
        cu_bus.ir_1 = 4'b1000;
        fetch(0);
        checks++; if (flags !== 3'b000) begin errors++; $display("FAIL illegal_pre: got %b want %b", flags, 3'b000); end
        step();
        checks++; if (flags !== 3'b010) begin errors++; $display("FAIL illegal_1000: got %b want %b", flags, 3'b010); end
        checks++; if (ctl !== C_FA) begin errors++; $display("FAIL illegal_1000_fa: got %h want %h", ctl, C_FA); end
        do_reset();
        checks++; if (flags !== 3'b000) begin errors++; $display("FAIL illegal_cleared: got %b want %b", flags, 3'b000); end
        cu_bus.ir_1 = 4'b0101;
        fetch(0);
        step();
        checks++; if (flags !== 3'b010) begin errors++; $display("FAIL illegal_push: got %b want %b", flags, 3'b010); end
        checks++; if (ctl !== C_FA) begin errors++; $display("FAIL illegal_push_fa: got %h want %h", ctl, C_FA); end
    endtask

    task automatic test_halt();
        do_reset();
        cu_bus.ir_1 = 4'b1111;
        fetch(0);
        step();
        checks++; if (flags !== 3'b100) begin errors++; $display("FAIL halt_flags: got %b want %b", flags, 3'b100); end
        checks++; if (ctl !== 17'h0) begin errors++; $display("FAIL halt_ctl: got %h want %h", ctl, 17'h0); end
        repeat (4) step();
        checks++; if (ctl !== 17'h0 || flags !== 3'b100) begin errors++; $display("FAIL halt_stays: got %h/%b want %h/%b", ctl, flags, 17'h0, 3'b100); end
    endtask

    task automatic test_timeout();
        do_reset();
        cu_bus.ir_1 = 4'b0000;
        step();
        repeat (15) step();
        checks++; if (ctl !== B_MEMRD || flags !== 3'b000) begin errors++; $display("FAIL timeout_last_wait: got %h/%b want %h/%b", ctl, flags, B_MEMRD, 3'b000); end
        step();
        checks++; if (flags !== 3'b101) begin errors++; $display("FAIL timeout_flags: got %b want %b", flags, 3'b101); end
        checks++; if (ctl !== 17'h0) begin errors++; $display("FAIL timeout_ctl: got %h want %h", ctl, 17'h0); end
        cu_bus.mem_ready = 1'b1;
        repeat (3) step();
        checks++; if (ctl !== 17'h0 || flags !== 3'b101) begin errors++; $display("FAIL timeout_stuck: got %h/%b want %h/%b", ctl, flags, 17'h0, 3'b101); end
        do_reset();
        checks++; if (flags !== 3'b000 || ctl !== C_FA) begin errors++; $display("FAIL timeout_recover: got %h/%b want %h/%b", ctl, flags, C_FA, 3'b000); end
    endtask

    // Reset asserted mid-store must drop mem_wr without waiting for an edge.
    task automatic test_reset_mid();
        cu_bus.ir_1 = 4'b0010;
        fetch(0);
        step();
        step();
        checks++; if (ctl !== (B_TREG | B_LDMDR | B_MEMWR)) begin errors++; $display("FAIL mid_store: got %h want %h", ctl, B_TREG | B_LDMDR | B_MEMWR); end
        #2 reset = 1'b0;
        #1;
        checks++; if (ctl !== 17'h0) begin errors++; $display("FAIL mid_async_clear: got %h want %h", ctl, 17'h0); end
        #2 reset = 1'b1;
        step();
        checks++; if (ctl !== C_FA) begin errors++; $display("FAIL mid_refetch_fa: got %h want %h", ctl, C_FA); end
        step();
        checks++; if (ctl !== B_MEMRD) begin errors++; $display("FAIL mid_refetch_mem: got %h want %h", ctl, B_MEMRD); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_alu();
        test_branch();
        test_load();
        test_store();
        test_timeout_race();
        test_illegal();
        test_halt();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
